// File: rtl/immgen_queue_pkg.sv
// Shared types and opcode constants for the decode-side immediate queue.
package immgen_queue_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6,
    FMT_R    = 3'd7
  } imm_fmt_t;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  // funct3 values that turn an OP-IMM into a shift (slli / srli / srai)
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;

endpackage

// File: rtl/immgen_core.sv
// Combinational instruction classifier and XLEN-wide immediate builder.
module immgen_core
  import immgen_queue_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instr,
  output imm_fmt_t        fmt,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
    logic [XLEN-1:0] r;
    r = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] zext6(input logic [5:0] v);
    logic [XLEN-1:0] r;
    r = '0;
    r[5:0] = v;
    return r;
  endfunction

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic               is_shift;
  logic signed [31:0] imm_i;
  logic signed [31:0] imm_s;
  logic signed [31:0] imm_b;
  logic signed [31:0] imm_u;
  logic signed [31:0] imm_j;
  logic [5:0]         shamt_w;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign is_shift = (funct3 == F3_SLL) || (funct3 == F3_SRL_SRA);
  assign imm_i    = {{20{instr[31]}}, instr[31:20]};
  assign imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u    = {instr[31:12], 12'b0};
  assign imm_j    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  // bit 25 of the shift amount is only meaningful on a 64-bit datapath
  assign shamt_w  = (XLEN == 64) ? instr[25:20] : {1'b0, instr[24:20]};

  // Opcode decode selects the format and the matching immediate layout.
  always_comb begin
    fmt     = FMT_NONE;
    imm     = '0;
    illegal = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        fmt = FMT_U;
        imm = sext32(imm_u);
      end
      OPC_JAL: begin
        fmt = FMT_J;
        imm = sext32(imm_j);
      end
      OPC_JALR, OPC_LOAD: begin
        fmt = FMT_I;
        imm = sext32(imm_i);
      end
      OPC_OP_IMM: begin
        fmt = FMT_I;
        imm = is_shift ? zext6(shamt_w) : sext32(imm_i);
      end
      OPC_OP_IMM_32: begin
        fmt = FMT_I;
        imm = is_shift ? zext6({1'b0, instr[24:20]}) : sext32(imm_i);
      end
      OPC_STORE: begin
        fmt = FMT_S;
        imm = sext32(imm_s);
      end
      OPC_BRANCH: begin
        fmt = FMT_B;
        imm = sext32(imm_b);
      end
      OPC_OP, OPC_OP_32: begin
        fmt = FMT_R;
      end
      OPC_SYSTEM: begin
        if (funct3[2]) begin
          fmt = FMT_Z;
          imm = zext6({1'b0, instr[19:15]});
        end else begin
          fmt = FMT_I;
          imm = sext32(imm_i);
        end
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/immgen_queue.sv
// Immediate generator feeding a small valid/ready FIFO between fetch and decode.
module immgen_queue
  import immgen_queue_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output imm_fmt_t        out_fmt,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]     mem_instr [DEPTH];
  logic [XLEN-1:0] mem_pc    [DEPTH];
  imm_fmt_t        mem_fmt   [DEPTH];
  logic [XLEN-1:0] mem_imm   [DEPTH];
  logic            mem_ill   [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  imm_fmt_t        dec_fmt;
  logic [XLEN-1:0] dec_imm;
  logic            dec_ill;
  logic            enq;
  logic            deq;

  immgen_core #(.XLEN(XLEN)) u_core (
    .instr   (in_instr),
    .fmt     (dec_fmt),
    .imm     (dec_imm),
    .illegal (dec_ill)
  );

  assign in_ready    = (count != CW'(DEPTH));
  assign out_valid   = (count != '0);
  assign enq         = in_valid & in_ready;
  assign deq         = out_valid & out_ready;

  assign out_instr   = mem_instr[rd_ptr];
  assign out_pc      = mem_pc[rd_ptr];
  assign out_fmt     = mem_fmt[rd_ptr];
  assign out_imm     = mem_imm[rd_ptr];
  assign out_illegal = mem_ill[rd_ptr];

  // Pointer and occupancy tracking; flush empties the queue and outranks handshakes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage: decoded result captured at enqueue, cleared on reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_instr[k] <= '0;
        mem_pc[k]    <= '0;
        mem_fmt[k]   <= FMT_NONE;
        mem_imm[k]   <= '0;
        mem_ill[k]   <= 1'b0;
      end
    end else if (enq && !flush) begin
      mem_instr[wr_ptr] <= in_instr;
      mem_pc[wr_ptr]    <= in_pc;
      mem_fmt[wr_ptr]   <= dec_fmt;
      mem_imm[wr_ptr]   <= dec_imm;
      mem_ill[wr_ptr]   <= dec_ill;
    end
  end

endmodule

// File: tb/tb_immgen_queue.sv
// Bench for immgen_queue: behavioural queue/decode model plus directed literal checks.
module tb_immgen_queue;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [63:0] in_pc = '0;

  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_instr;
  logic [63:0] out_pc, out_imm;
  logic [2:0]  out_fmt;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_instr32, out_pc32, out_imm32;
  logic [2:0]  out_fmt32;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } ent_t;
  ent_t mq[$];

  always #5 clk = ~clk;

  immgen_queue #(.XLEN(64), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_fmt(out_fmt), .out_imm(out_imm), .out_illegal(out_illegal)
  );

  immgen_queue #(.XLEN(32), .DEPTH(DEPTH)) dut32 (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr), .in_pc(in_pc[31:0]),
    .out_valid(out_valid32), .out_ready(out_ready), .out_instr(out_instr32), .out_pc(out_pc32),
    .out_fmt(out_fmt32), .out_imm(out_imm32), .out_illegal(out_illegal32)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference decode straight from the RV immediate rules (fmt codes 0..7 = NONE,I,S,B,U,J,Z,R).
  function automatic void ref_dec(input logic [31:0] i, input int xl,
                                  output logic [2:0] f, output logic [63:0] imm, output logic ill);
    longint v;
    logic [6:0] op;
    logic [2:0] f3;
    op = i[6:0]; f3 = i[14:12]; v = 0; ill = 1'b0; f = 3'd0;
    case (op)
      7'h37, 7'h17: begin f = 3'd4; v = longint'($signed(i & 32'hFFFF_F000)); end
      7'h6F: begin f = 3'd5; v = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})); end
      7'h67, 7'h03: begin f = 3'd1; v = longint'($signed(i[31:20])); end
      7'h13: begin
        f = 3'd1;
        if (f3 == 3'd1 || f3 == 3'd5) v = (xl == 64) ? longint'(i[25:20]) : longint'(i[24:20]);
        else v = longint'($signed(i[31:20]));
      end
      7'h1B: begin
        f = 3'd1;
        if (f3 == 3'd1 || f3 == 3'd5) v = longint'(i[24:20]);
        else v = longint'($signed(i[31:20]));
      end
      7'h23: begin f = 3'd2; v = longint'($signed({i[31:25], i[11:7]})); end
      7'h63: begin f = 3'd3; v = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})); end
      7'h33, 7'h3B: f = 3'd7;
      7'h73: begin
        if (f3[2]) begin f = 3'd6; v = longint'(i[19:15]); end
        else begin f = 3'd1; v = longint'($signed(i[31:20])); end
      end
      default: ill = 1'b1;
    endcase
    if (xl == 64) imm = v;
    else imm = {32'h0, v[31:0]};
  endfunction

  // Model queue: same acceptance rules as the spec, updated on each active edge.
  always @(posedge clk) begin
    bit acc, dq;
    if (resetn) begin
      acc = in_valid && (mq.size() < DEPTH);
      dq  = out_ready && (mq.size() > 0);
      if (flush) mq.delete();
      else begin
        if (dq) void'(mq.pop_front());
        if (acc) mq.push_back({in_instr, in_pc});
      end
    end
  end

  always @(negedge resetn) mq.delete();

  // Every cycle: handshake flags and head entry of both widths against the model.
  always @(negedge clk) begin
    logic [2:0]  f;
    logic [63:0] imm;
    logic        ill;
    chk("in_ready", in_ready, mq.size() < DEPTH);
    chk("in_ready32", in_ready32, mq.size() < DEPTH);
    chk("out_valid", out_valid, mq.size() != 0);
    chk("out_valid32", out_valid32, mq.size() != 0);
    if (mq.size() != 0) begin
      ref_dec(mq[0].instr, 64, f, imm, ill);
      chk("head_instr", out_instr, mq[0].instr);
      chk("head_pc", out_pc, mq[0].pc);
      chk("head_fmt", out_fmt, f);
      chk("head_imm", out_imm, imm);
      chk("head_ill", out_illegal, ill);
      ref_dec(mq[0].instr, 32, f, imm, ill);
      chk("head32_instr", out_instr32, mq[0].instr);
      chk("head32_pc", out_pc32, mq[0].pc[31:0]);
      chk("head32_fmt", out_fmt32, f);
      chk("head32_imm", out_imm32, imm[31:0]);
      chk("head32_ill", out_illegal32, ill);
    end
  end

  // One cycle of stimulus, called at a falling edge; samples handshakes just before the rise.
  task automatic step(input logic iv, input logic [31:0] ins, input logic [63:0] pc,
                      input logic ordy, input logic fl,
                      output logic acc, output logic dq, output logic [31:0] dq_instr);
    in_valid = iv; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
    #4;
    acc = iv && in_ready;
    dq = ordy && out_valid;
    dq_instr = out_instr;
    @(negedge clk);
  endtask

  task automatic drain();
    logic a, d;
    logic [31:0] x;
    repeat (3) step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, a, d, x);
  endtask

  task automatic directed(input string nm, input logic [31:0] ins, input logic [2:0] f,
                          input logic [63:0] i64, input logic [31:0] i32, input logic ill);
    logic a, d;
    logic [31:0] x;
    drain();
    chk({nm, "_empty_before"}, out_valid, 1'b0);
    step(1'b1, ins, 64'h8000_0000_0000_1000, 1'b0, 1'b0, a, d, x);
    chk({nm, "_accept"}, a, 1'b1);
    chk({nm, "_valid_next"}, out_valid, 1'b1);
    chk({nm, "_instr"}, out_instr, ins);
    chk({nm, "_fmt"}, out_fmt, f);
    chk({nm, "_imm64"}, out_imm, i64);
    chk({nm, "_imm32"}, out_imm32, i32);
    chk({nm, "_ill"}, out_illegal, ill);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, a, d, x);
  endtask

  logic [31:0] abc [3];
  logic [31:0] got[$];
  logic [6:0]  ops [13];

  initial begin
    logic a, d;
    logic [31:0] x, r;
    int k;

    abc[0] = 32'hFFF0_0093; abc[1] = 32'h8000_00B7; abc[2] = 32'h0011_2623;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h33, 7'h3B, 7'h73, 7'h7F};

    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_imm", out_imm, 64'h0);
    #2 resetn = 1'b1;
    @(negedge clk);

    directed("addi",   32'hFFF0_0093, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    directed("beq",    32'hFE00_0EE3, 3'd3, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
    directed("lui",    32'h8000_00B7, 3'd4, 64'hFFFF_FFFF_8000_0000, 32'h8000_0000, 1'b0);
    directed("srai",   32'h43F0_D093, 3'd1, 64'h0000_0000_0000_003F, 32'h0000_001F, 1'b0);
    directed("csrrwi", 32'h300F_D073, 3'd6, 64'h0000_0000_0000_001F, 32'h0000_001F, 1'b0);
    directed("illeg",  32'h0000_007F, 3'd0, 64'h0, 32'h0, 1'b1);

    // Fill with the consumer stalled, then release and watch ordering.
    drain();
    k = 0;
    for (int c = 0; c < 5; c++) begin
      step(k < 3, abc[(k < 3) ? k : 0], 64'h100 + 64'(k), 1'b0, 1'b0, a, d, x);
      if (a) k++;
      if (k == 2) chk("stall_head_stable", out_instr, abc[0]);
    end
    chk("full_accepts", k, 2);
    chk("full_in_ready", in_ready, 1'b0);
    got.delete();
    for (int c = 0; c < 12 && got.size() < 3; c++) begin
      step(k < 3, abc[(k < 3) ? k : 0], 64'h100 + 64'(k), 1'b1, 1'b0, a, d, x);
      if (a) k++;
      if (d) got.push_back(x);
    end
    chk("order_count", got.size(), 3);
    for (int j = 0; j < 3; j++)
      chk("order_entry", (j < got.size()) ? got[j] : 32'hDEAD_BEEF, abc[j]);

    // Flush with two queued entries and a same-cycle offer.
    drain();
    step(1'b1, 32'h0000_1537, 64'h200, 1'b0, 1'b0, a, d, x);
    step(1'b1, 32'h0000_2597, 64'h204, 1'b0, 1'b0, a, d, x);
    chk("flush_prefull", in_ready, 1'b0);
    step(1'b1, 32'h0040_0613, 64'h208, 1'b1, 1'b1, a, d, x);
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, a, d, x);
      chk("flush_stays_empty", out_valid, 1'b0);
    end

    // Asynchronous reset between edges with an entry held.
    step(1'b1, 32'h0050_0693, 64'h300, 1'b0, 1'b0, a, d, x);
    chk("pre_reset_valid", out_valid, 1'b1);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 1'b0);
    chk("async_rst_instr", out_instr, 32'h0);
    @(negedge clk);
    #2 resetn = 1'b1;
    @(negedge clk);
    directed("post_rst", 32'hFFF0_0093, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

    // Randomised traffic, occasional flushes.
    for (int c = 0; c < 600; c++) begin
      r = $urandom;
      x = {r[31:7], ops[$urandom_range(0, 12)]};
      step($urandom_range(0, 3) != 0, x, {$urandom, $urandom},
           $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0, a, d, r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
